// File: rtl/serial_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : serial_receiver
// Description : UART-style receiver using serclk rising edges as oversample
//               ticks; single holding register with valid/ack handshake.
//               Optional parity bit enabled by defining SERIAL_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 serclk,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int c_TW = $clog2(OVERSAMPLE);
  localparam int c_BW = $clog2(DATA_BITS);

  localparam logic [c_TW-1:0] c_TICK_MID  = c_TW'(OVERSAMPLE / 2 - 1);
  localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(OVERSAMPLE - 1);
  localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(DATA_BITS - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_STOP   = 3'd3;
`ifdef SERIAL_RX_PARITY_EN
  localparam logic [2:0] c_PARITY = 3'd4;
`endif

  logic                 r_rxd_m;
  logic                 r_rxd_s;
  logic                 r_serclk_q;
  logic [2:0]           r_state;
  logic [c_TW-1:0]      r_tick_cnt;
  logic [c_BW-1:0]      r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;

  logic                 w_tick;
  logic                 w_bit_end;
  logic                 w_commit;
  logic [c_TW-1:0]      w_tick_next;

  assign w_tick      = serclk & ~r_serclk_q;
  assign w_tick_next = (r_tick_cnt == c_TICK_LAST) ? '0 : r_tick_cnt + c_TW'(1);
  assign w_bit_end   = w_tick && (r_tick_cnt == c_TICK_LAST);
  assign w_commit    = w_bit_end && (r_state == c_STOP);
  assign busy        = (r_state != c_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rxd_m    <= 1'b1;
      r_rxd_s    <= 1'b1;
      r_serclk_q <= 1'b0;
    end else begin
      r_rxd_m    <= rxd;
      r_rxd_s    <= r_rxd_m;
      r_serclk_q <= serclk;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  logic r_par_bit;
  logic w_par_err;

  assign w_par_err = (^r_shift) ^ r_par_bit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_par_bit <= 1'b0;
    end else if (w_bit_end && (r_state == c_PARITY)) begin
      r_par_bit <= r_rxd_s;
    end
  end
`endif

  // Everything below advances only on a tick; between ticks all state holds.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= c_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else if (w_tick) begin
      case (r_state)
        c_IDLE: begin
          if (!r_rxd_s) begin
            r_state    <= c_START;
            r_tick_cnt <= c_TW'(1);
          end
        end
        c_START: begin
          if (r_tick_cnt == c_TICK_MID) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_state    <= r_rxd_s ? c_IDLE : c_DATA;
          end else begin
            r_tick_cnt <= w_tick_next;
          end
        end
        c_DATA: begin
          r_tick_cnt <= w_tick_next;
          if (r_tick_cnt == c_TICK_LAST) begin
            r_shift   <= {r_rxd_s, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + c_BW'(1);
            if (r_bit_cnt == c_BIT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
              r_state <= c_PARITY;
`else
              r_state <= c_STOP;
`endif
            end
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        c_PARITY: begin
          r_tick_cnt <= w_tick_next;
          if (r_tick_cnt == c_TICK_LAST) begin
            r_state <= c_STOP;
          end
        end
`endif
        c_STOP: begin
          r_tick_cnt <= w_tick_next;
          if (r_tick_cnt == c_TICK_LAST) begin
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_state    <= c_IDLE;
          r_tick_cnt <= '0;
        end
      endcase
    end
  end

  // A commit with a coincident ack replaces the held byte instead of overrunning.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data          <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else if (w_commit) begin
      if (!data_valid || data_ack) begin
        data          <= r_shift;
        data_valid    <= 1'b1;
        framing_error <= ~r_rxd_s;
        overrun       <= 1'b0;
      end else begin
        overrun       <= 1'b1;
      end
    end else if (data_ack && data_valid) begin
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      parity_error <= 1'b0;
    end else if (w_commit) begin
      if (!data_valid || data_ack) begin
        parity_error <= w_par_err;
      end
    end else if (data_ack && data_valid) begin
      parity_error <= 1'b0;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule
`default_nettype wire
